// File: rtl/crc_serial_rx.sv
// rtl/crc_serial_rx.sv - MSB-first serial frame receiver with CRC check, Done/Frame_err strobes
module crc_serial_rx #(
  parameter int unsigned      DATA_W = 16,
  parameter int unsigned      CRC_W  = 4,
  parameter logic [CRC_W-1:0] POLY   = 4'h3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic              Sin,
  output logic [DATA_W-1:0] Dout,
  output logic [CRC_W-1:0]  Crc_rx,
  output logic              Crc_ok,
  output logic              Done,
  output logic              Busy,
  output logic              Frame_err
);

  localparam int unsigned      FRAME_W  = DATA_W + CRC_W;
  localparam int unsigned      CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_HOLD
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  // Holds all but the newest bit; the final bit joins straight from Sin at capture.
  logic [FRAME_W-2:0]   r_sr, w_sr_nxt;
  logic [CRC_W-1:0]     r_rem, w_rem_nxt;
  logic [DATA_W-1:0]    r_dout, w_dout_nxt;
  logic [CRC_W-1:0]     r_crc_rx, w_crc_rx_nxt;
  logic                 r_crc_ok, w_crc_ok_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_frame_err, w_frame_err_nxt;

  logic [FRAME_W-2:0]   w_sr_base;
  logic [CRC_W-1:0]     w_rem_base;
  logic [FRAME_W-1:0]   w_frame;
  logic                 w_fb;
  logic [CRC_W-1:0]     w_rem_step;

  // A frame always starts from an empty shift register and a zero remainder.
  assign w_sr_base  = (r_state == S_IDLE) ? '0 : r_sr;
  assign w_rem_base = (r_state == S_IDLE) ? '0 : r_rem;
  assign w_frame    = {w_sr_base, Sin};
  assign w_fb       = w_rem_base[CRC_W-1] ^ Sin;
  assign w_rem_step = {w_rem_base[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_sr_nxt        = r_sr;
    w_rem_nxt       = r_rem;
    w_dout_nxt      = r_dout;
    w_crc_rx_nxt    = r_crc_rx;
    w_crc_ok_nxt    = r_crc_ok;
    w_done_nxt      = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (En) begin
          w_sr_nxt    = w_frame[FRAME_W-2:0];
          w_rem_nxt   = w_rem_step;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = S_RECV;
        end
      end
      S_RECV: begin
        if (En) begin
          w_sr_nxt  = w_frame[FRAME_W-2:0];
          w_rem_nxt = w_rem_step;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            w_dout_nxt   = w_frame[FRAME_W-1:CRC_W];
            w_crc_rx_nxt = w_frame[CRC_W-1:0];
            w_crc_ok_nxt = (w_rem_step == '0);
            w_done_nxt   = 1'b1;
            w_state_nxt  = S_HOLD;
          end
        end else begin
          w_frame_err_nxt = 1'b1;
          w_cnt_nxt       = '0;
          w_sr_nxt        = '0;
          w_rem_nxt       = '0;
          w_state_nxt     = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!En) begin
          w_cnt_nxt   = '0;
          w_sr_nxt    = '0;
          w_rem_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_sr_nxt    = '0;
        w_rem_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_rem       <= '0;
      r_dout      <= '0;
      r_crc_rx    <= '0;
      r_crc_ok    <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sr        <= w_sr_nxt;
      r_rem       <= w_rem_nxt;
      r_dout      <= w_dout_nxt;
      r_crc_rx    <= w_crc_rx_nxt;
      r_crc_ok    <= w_crc_ok_nxt;
      r_done      <= w_done_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign Dout      = r_dout;
  assign Crc_rx    = r_crc_rx;
  assign Crc_ok    = r_crc_ok;
  assign Done      = r_done;
  assign Frame_err = r_frame_err;
  assign Busy      = (r_state == S_RECV);

endmodule

// File: tb/tb_crc_serial_rx.sv
// tb/tb_crc_serial_rx.sv - randomized self-checking bench for crc_serial_rx against a polynomial-division model
module tb_crc_serial_rx;

  logic        Clk, Reset, En, Sin;
  logic [15:0] Dout;
  logic [3:0]  Crc_rx;
  logic        Crc_ok, Done, Busy, Frame_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  logic [15:0] exp_dout;
  logic [3:0]  exp_crc;
  logic        exp_ok;

  crc_serial_rx dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Sin(Sin),
    .Dout(Dout), .Crc_rx(Crc_rx), .Crc_ok(Crc_ok),
    .Done(Done), .Busy(Busy), .Frame_err(Frame_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Done) done_cnt++;
    if (Frame_err) err_cnt++;
    if (Done && Frame_err) both_cnt++;
  end

  // Remainder of the frame polynomial divided by x^4+x+1, by long division.
  function automatic logic [3:0] polymod(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int i = 19; i >= 4; i--)
      if (r[i]) r = r ^ (20'h13 << (i - 4));
    return r[3:0];
  endfunction

  task automatic run_frame(input logic [19:0] frame, input int hold);
    int   d0, e0;
    logic hold_ok;
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk); En = 1'b1; Sin = frame[19-i];
      if (i == 10) begin
        @(posedge Clk); #1;
        checks++;
        if (Busy !== 1'b1) begin errors++; $display("FAIL busy_mid_frame: got %b expected 1", Busy); end
      end
    end
    @(posedge Clk); #1;
    exp_dout = frame[19:4];
    exp_crc  = frame[3:0];
    exp_ok   = (polymod(frame) == 4'h0);
    checks++;
    if (Done !== 1'b1) begin errors++; $display("FAIL done_strobe frame %h: got %b expected 1", frame, Done); end
    checks++;
    if (Dout !== exp_dout) begin errors++; $display("FAIL dout frame %h: got %h expected %h", frame, Dout, exp_dout); end
    checks++;
    if (Crc_rx !== exp_crc) begin errors++; $display("FAIL crc_rx frame %h: got %h expected %h", frame, Crc_rx, exp_crc); end
    checks++;
    if (Crc_ok !== exp_ok) begin errors++; $display("FAIL crc_ok frame %h: got %b expected %b", frame, Crc_ok, exp_ok); end
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL early_done frame %h: got %0d strobes expected 0", frame, done_cnt - d0); end
    hold_ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge Clk); En = 1'b1; Sin = 1'($urandom_range(0, 1));
      @(posedge Clk); #1;
      if (Busy !== 1'b0 || Done !== 1'b0) hold_ok = 1'b0;
    end
    if (hold > 0) begin
      checks++;
      if (hold_ok !== 1'b1) begin errors++; $display("FAIL hold_idle: got %b expected 1", hold_ok); end
      checks++;
      if ({Dout, Crc_rx, Crc_ok} !== {exp_dout, exp_crc, exp_ok})
        begin errors++; $display("FAIL hold_outputs: got %h/%h/%b expected %h/%h/%b", Dout, Crc_rx, Crc_ok, exp_dout, exp_crc, exp_ok); end
    end
    @(negedge Clk); En = 1'b0; Sin = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if ({Done, Busy} !== 2'b00) begin errors++; $display("FAIL after_frame done/busy: got %b expected 00", {Done, Busy}); end
    checks++;
    if (done_cnt != d0 + 1 || err_cnt != e0)
      begin errors++; $display("FAIL strobe_count frame %h: got done=%0d err=%0d expected done=1 err=0", frame, done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_reset();
    Reset = 1'b0; En = 1'b0; Sin = 1'b0;
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({Dout, Crc_rx, Crc_ok, Done, Busy, Frame_err} !== 24'h0)
      begin errors++; $display("FAIL reset_outputs: got %h expected 0", {Dout, Crc_rx, Crc_ok, Done, Busy, Frame_err}); end
    @(posedge Clk); #1;
    checks++;
    if ({Dout, Crc_rx, Crc_ok, Done, Busy, Frame_err} !== 24'h0)
      begin errors++; $display("FAIL reset_held: got %h expected 0", {Dout, Crc_rx, Crc_ok, Done, Busy, Frame_err}); end
    @(negedge Clk); Reset = 1'b0;
    exp_dout = '0; exp_crc = '0; exp_ok = 1'b0;
  endtask

  task automatic test_known_frames();
    run_frame(20'h00013, 0);
    run_frame(20'h80003, 0);
    run_frame(20'h00012, 0);
  endtask

  task automatic test_hold();
    run_frame(20'h00013, 10);
  endtask

  task automatic test_frame_err(input int nbits);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < nbits; i++) begin
      @(negedge Clk); En = 1'b1; Sin = 1'($urandom_range(0, 1));
    end
    @(negedge Clk); En = 1'b0; Sin = 1'($urandom_range(0, 1));
    @(posedge Clk); #1;
    checks++;
    if ({Frame_err, Done, Busy} !== 3'b100)
      begin errors++; $display("FAIL frame_err_%0d err/done/busy: got %b expected 100", nbits, {Frame_err, Done, Busy}); end
    checks++;
    if ({Dout, Crc_rx, Crc_ok} !== {exp_dout, exp_crc, exp_ok})
      begin errors++; $display("FAIL frame_err_%0d outputs: got %h/%h/%b expected %h/%h/%b", nbits, Dout, Crc_rx, Crc_ok, exp_dout, exp_crc, exp_ok); end
    @(posedge Clk); #1;
    checks++;
    if (Frame_err !== 1'b0) begin errors++; $display("FAIL frame_err_%0d width: got %b expected 0", nbits, Frame_err); end
    checks++;
    if (err_cnt != e0 + 1 || done_cnt != d0)
      begin errors++; $display("FAIL frame_err_%0d counts: got err=%0d done=%0d expected err=1 done=0", nbits, err_cnt - e0, done_cnt - d0); end
  endtask

  task automatic test_random_frames();
    logic [15:0] data;
    logic [3:0]  crc;
    int          gap;
    for (int n = 0; n < 12; n++) begin
      data = 16'($urandom);
      crc  = polymod({data, 4'h0});
      if ($urandom_range(0, 1) == 1) crc = crc ^ 4'($urandom_range(1, 15));
      run_frame({data, crc}, 0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge Clk);
    end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    logic [19:0] f;
    f = 20'h00013;
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk); En = 1'b1; Sin = f[19-i];
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({Dout, Crc_rx, Crc_ok, Done, Busy, Frame_err} !== 24'h0)
      begin errors++; $display("FAIL reset_mid_outputs: got %h expected 0", {Dout, Crc_rx, Crc_ok, Done, Busy, Frame_err}); end
    En = 1'b0;
    @(negedge Clk); Reset = 1'b0;
    exp_dout = '0; exp_crc = '0; exp_ok = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (done_cnt != d0 || err_cnt != e0)
      begin errors++; $display("FAIL reset_mid_strobes: got done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0); end
    run_frame(20'h00013, 0);
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    run_frame(20'h00013, 0);
    run_frame(20'h80003, 0);
    checks++;
    if (done_cnt != d0 + 2) begin errors++; $display("FAIL back_to_back_count: got %0d expected 2", done_cnt - d0); end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_cnt != 0) begin errors++; $display("FAIL done_and_frame_err_together: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_known_frames();
    test_hold();
    test_frame_err(11);
    test_frame_err(19);
    test_frame_err(1);
    test_random_frames();
    test_reset_mid();
    test_back_to_back();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
